// File: rtl/stream_mux_pkg.sv
// Shared constants for the handshaked N:1 stream multiplexer and its arbiter.
package stream_mux_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE   = 1'b0;
    localparam state_t ST_LOCKED = 1'b1;

    // Channel index width; a two-channel mux still needs one bit.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Picks one requesting channel: first request after the pointer (round-robin)
// or lowest requesting index (fixed priority).
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int MODE = MODE_RR,
    localparam int CH_W = ch_width(N_CH)
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [CH_W-1:0] ptr_i,
    output logic [N_CH-1:0] grant_o,
    output logic [CH_W-1:0] grant_idx_o,
    output logic            grant_vld_o
);

    int base;
    int cand;

    // Fixed priority is the rotating search with the pointer pinned at the top
    // channel, so the scan always starts from index 0.
    always_comb begin
        base        = (MODE == MODE_FIXED) ? (N_CH - 1) : int'(ptr_i);
        cand        = 0;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        for (int off = N_CH; off >= 1; off--) begin
            cand = (base + off) % N_CH;
            if (req_i[CH_W'(cand)]) begin
                grant_idx_o = CH_W'(cand);
                grant_vld_o = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_onehot
        assign grant_o[gi] = grant_vld_o && (grant_idx_o == CH_W'(gi));
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with per-packet channel lock and a single
// registered output beat tagged with its source channel.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int MODE   = MODE_RR,
    localparam int CH_W  = ch_width(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_last,
    output logic [CH_W-1:0]        out_ch
);

    state_t              state_q, state_d;
    logic [CH_W-1:0]     lock_ch_q, lock_ch_d;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic [CH_W-1:0]     out_ch_q, out_ch_d;

    logic [N_CH-1:0]     arb_grant;
    logic [CH_W-1:0]     arb_idx;
    logic                arb_vld;
    logic [N_CH-1:0]     lock_oh;

    logic                load_en;
    logic                locked;
    logic [CH_W-1:0]     sel_idx;
    logic                sel_vld;
    logic [N_CH-1:0]     sel_oh;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_last;
    logic                accept;

    rr_arbiter #(
        .N_CH (N_CH),
        .MODE (MODE)
    ) u_arb (
        .req_i       (in_valid),
        .ptr_i       (rr_ptr_q),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx),
        .grant_vld_o (arb_vld)
    );

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_lock_oh
        assign lock_oh[gi] = (lock_ch_q == CH_W'(gi));
    end

    assign load_en = !out_valid_q || out_ready;
    assign locked  = (state_q == ST_LOCKED);

    // While a packet is in flight only the locked channel may be granted,
    // even if it is momentarily not valid.
    always_comb begin
        sel_idx  = locked ? lock_ch_q : arb_idx;
        sel_vld  = locked ? in_valid[lock_ch_q] : arb_vld;
        sel_oh   = locked ? lock_oh : arb_grant;
        sel_data = in_data[int'(sel_idx)*DATA_W +: DATA_W];
        sel_last = in_last[sel_idx];
        accept   = rst_n && load_en && sel_vld;
        in_ready = accept ? sel_oh : '0;
    end

    always_comb begin
        state_d     = state_q;
        lock_ch_d   = lock_ch_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_ch_d    = sel_idx;
            if (!locked) begin
                if (MODE == MODE_RR) begin
                    rr_ptr_d = sel_idx;
                end
                if (!sel_last) begin
                    state_d   = ST_LOCKED;
                    lock_ch_d = sel_idx;
                end
            end else if (sel_last) begin
                state_d = ST_IDLE;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lock_ch_q   <= '0;
            rr_ptr_q    <= CH_W'(N_CH - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scenario bench for stream_mux_rr: a round-robin and a fixed-priority instance
// share clock and reset; expected beats go through per-instance queues.
module tb_stream_mux_rr;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic        clk;
    logic        rst_n;

    logic [3:0]  rr_valid, rr_ready, rr_last;
    logic [31:0] rr_data;
    logic        rr_out_valid, rr_out_ready, rr_out_last;
    logic [7:0]  rr_out_data;
    logic [1:0]  rr_out_ch;

    logic [3:0]  fp_valid, fp_ready, fp_last;
    logic [31:0] fp_data;
    logic        fp_out_valid, fp_out_ready, fp_out_last;
    logic [7:0]  fp_out_data;
    logic [1:0]  fp_out_ch;

    beat_t q_rr[$];
    beat_t q_fp[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    stream_mux_rr #(.N_CH(4), .DATA_W(8), .MODE(0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .in_valid(rr_valid), .in_ready(rr_ready), .in_data(rr_data), .in_last(rr_last),
        .out_valid(rr_out_valid), .out_ready(rr_out_ready), .out_data(rr_out_data),
        .out_last(rr_out_last), .out_ch(rr_out_ch)
    );

    stream_mux_rr #(.N_CH(4), .DATA_W(8), .MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .in_valid(fp_valid), .in_ready(fp_ready), .in_data(fp_data), .in_last(fp_last),
        .out_valid(fp_out_valid), .out_ready(fp_out_ready), .out_data(fp_out_data),
        .out_last(fp_out_last), .out_ch(fp_out_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        rr_valid = '0; rr_last = '0; rr_data = '0; rr_out_ready = 1'b1;
        fp_valid = '0; fp_last = '0; fp_data = '0; fp_out_ready = 1'b1;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        beat_t exp;
        rst_n = 1'b0;
        idle_inputs();
        rr_valid = 4'hF; rr_last = 4'hF; rr_data = 32'h13121110;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (rr_out_valid !== 1'b0 || rr_out_ch !== 2'd0 || rr_out_data !== 8'h00 || rr_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state: got v=%0b ch=%0d data=%02h ready=%04b, want v=0 ch=0 data=00 ready=0000",
                     rr_out_valid, rr_out_ch, rr_out_data, rr_ready);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (rr_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_grant: got ready=%04b, want 0001", rr_ready);
        end
        q_rr.push_back('{ch: 2'd0, data: 8'h10, last: 1'b1});
        step();
        exp = q_rr.pop_front();
        n_checks++;
        if (rr_out_valid !== 1'b1 || rr_out_ch !== exp.ch || rr_out_data !== exp.data || rr_out_last !== exp.last) begin
            n_fail++;
            $display("FAIL reset_beat: got v=%0b ch=%0d data=%02h last=%0b, want v=1 ch=%0d data=%02h last=%0b",
                     rr_out_valid, rr_out_ch, rr_out_data, rr_out_last, exp.ch, exp.data, exp.last);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (rr_out_valid !== 1'b0 || rr_out_ch !== 2'd0 || rr_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_async: got v=%0b ch=%0d ready=%04b, want v=0 ch=0 ready=0000",
                     rr_out_valid, rr_out_ch, rr_ready);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (rr_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_regrant: got ready=%04b, want 0001", rr_ready);
        end
        q_rr.push_back('{ch: 2'd0, data: 8'h10, last: 1'b1});
        step();
        exp = q_rr.pop_front();
        n_checks++;
        if (rr_out_valid !== 1'b1 || rr_out_ch !== exp.ch || rr_out_data !== exp.data) begin
            n_fail++;
            $display("FAIL reset_regrant_beat: got v=%0b ch=%0d data=%02h, want v=1 ch=%0d data=%02h",
                     rr_out_valid, rr_out_ch, rr_out_data, exp.ch, exp.data);
        end
        $display("test_reset done");
        idle_inputs();
        step();
    endtask

    task automatic test_round_robin;
        beat_t exp;
        do_reset();
        rr_valid = 4'hF; rr_last = 4'hF;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++) rr_data[i*8 +: 8] = 8'(k*16 + i);
            #1;
            n_checks++;
            if (rr_ready !== (4'b0001 << (k % 4))) begin
                n_fail++;
                $display("FAIL rr_ready[%0d]: got %04b, want %04b", k, rr_ready, 4'b0001 << (k % 4));
            end
            q_rr.push_back('{ch: 2'(k % 4), data: 8'(k*16 + k % 4), last: 1'b1});
            step();
            exp = q_rr.pop_front();
            n_checks++;
            if (rr_out_valid !== 1'b1 || rr_out_ch !== exp.ch || rr_out_data !== exp.data) begin
                n_fail++;
                $display("FAIL rr_beat[%0d]: got v=%0b ch=%0d data=%02h, want v=1 ch=%0d data=%02h",
                         k, rr_out_valid, rr_out_ch, rr_out_data, exp.ch, exp.data);
            end
            $display("rr beat %0d: ch=%0d data=%02h", k, rr_out_ch, rr_out_data);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_packet_lock;
        beat_t exp;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            rr_valid = (k < 3) ? 4'b0110 : 4'b0100;
            rr_last  = {1'b0, 1'b1, (k == 2), 1'b0};
            rr_data  = {8'h00, 8'(8'h50 + k), 8'(8'h40 + k), 8'h00};
            #1;
            n_checks++;
            if (rr_ready !== ((k < 3) ? 4'b0010 : 4'b0100)) begin
                n_fail++;
                $display("FAIL lock_ready[%0d]: got %04b, want %04b", k, rr_ready, (k < 3) ? 4'b0010 : 4'b0100);
            end
            if (k < 3) q_rr.push_back('{ch: 2'd1, data: 8'(8'h40 + k), last: (k == 2)});
            else       q_rr.push_back('{ch: 2'd2, data: 8'(8'h50 + k), last: 1'b1});
            step();
            exp = q_rr.pop_front();
            n_checks++;
            if (rr_out_valid !== 1'b1 || rr_out_ch !== exp.ch || rr_out_data !== exp.data || rr_out_last !== exp.last) begin
                n_fail++;
                $display("FAIL lock_beat[%0d]: got v=%0b ch=%0d data=%02h last=%0b, want v=1 ch=%0d data=%02h last=%0b",
                         k, rr_out_valid, rr_out_ch, rr_out_data, rr_out_last, exp.ch, exp.data, exp.last);
            end
            $display("lock beat %0d: ch=%0d data=%02h last=%0b", k, rr_out_ch, rr_out_data, rr_out_last);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_backpressure;
        beat_t exp;
        do_reset();
        rr_valid = 4'b0001; rr_last = 4'b0001; rr_data = 32'h000000A5;
        #1;
        n_checks++;
        if (rr_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL bp_first_ready: got %04b, want 0001", rr_ready);
        end
        q_rr.push_back('{ch: 2'd0, data: 8'hA5, last: 1'b1});
        step();
        exp = q_rr.pop_front();
        n_checks++;
        if (rr_out_valid !== 1'b1 || rr_out_data !== exp.data || rr_out_ch !== exp.ch) begin
            n_fail++;
            $display("FAIL bp_first_beat: got v=%0b ch=%0d data=%02h, want v=1 ch=%0d data=%02h",
                     rr_out_valid, rr_out_ch, rr_out_data, exp.ch, exp.data);
        end
        rr_out_ready = 1'b0;
        rr_data = 32'h0000005A;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++;
            if (rr_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_ready[%0d]: got %04b, want 0000", k, rr_ready);
            end
            step();
            n_checks++;
            if (rr_out_valid !== 1'b1 || rr_out_data !== 8'hA5) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%0b data=%02h, want v=1 data=a5", k, rr_out_valid, rr_out_data);
            end
            $display("bp stall %0d: data=%02h", k, rr_out_data);
        end
        rr_out_ready = 1'b1;
        #1;
        n_checks++;
        if (rr_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %04b, want 0001", rr_ready);
        end
        q_rr.push_back('{ch: 2'd0, data: 8'h5A, last: 1'b1});
        step();
        exp = q_rr.pop_front();
        n_checks++;
        if (rr_out_valid !== 1'b1 || rr_out_data !== exp.data) begin
            n_fail++;
            $display("FAIL bp_release_beat: got v=%0b data=%02h, want v=1 data=%02h", rr_out_valid, rr_out_data, exp.data);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_fixed_priority;
        beat_t exp;
        logic [3:0] v_tab [8];
        logic [3:0] l_tab [8];
        logic [1:0] c_tab [8];
        v_tab = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1010, 4'b1010, 4'b1010};
        l_tab = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0010, 4'b0010, 4'b1010, 4'b1010};
        c_tab = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd1};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            fp_valid = v_tab[k];
            fp_last  = l_tab[k];
            fp_data  = {8'(8'h70 + k), 8'h00, 8'(8'h60 + k), 8'h00};
            #1;
            n_checks++;
            if (fp_ready !== (4'b0001 << c_tab[k])) begin
                n_fail++;
                $display("FAIL fp_ready[%0d]: got %04b, want %04b", k, fp_ready, 4'b0001 << c_tab[k]);
            end
            q_fp.push_back('{ch: c_tab[k], data: (c_tab[k] == 2'd3) ? 8'(8'h70 + k) : 8'(8'h60 + k),
                             last: l_tab[k][c_tab[k]]});
            step();
            exp = q_fp.pop_front();
            n_checks++;
            if (fp_out_valid !== 1'b1 || fp_out_ch !== exp.ch || fp_out_data !== exp.data || fp_out_last !== exp.last) begin
                n_fail++;
                $display("FAIL fp_beat[%0d]: got v=%0b ch=%0d data=%02h last=%0b, want v=1 ch=%0d data=%02h last=%0b",
                         k, fp_out_valid, fp_out_ch, fp_out_data, fp_out_last, exp.ch, exp.data, exp.last);
            end
            $display("fp beat %0d: ch=%0d data=%02h", k, fp_out_ch, fp_out_data);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_lock_stall;
        beat_t exp;
        do_reset();
        rr_valid = 4'b0001; rr_last = 4'b0100; rr_data = 32'h00C000A0;
        #1;
        q_rr.push_back('{ch: 2'd0, data: 8'hA0, last: 1'b0});
        step();
        exp = q_rr.pop_front();
        n_checks++;
        if (rr_out_valid !== 1'b1 || rr_out_ch !== exp.ch || rr_out_data !== exp.data || rr_out_last !== exp.last) begin
            n_fail++;
            $display("FAIL stall_head: got v=%0b ch=%0d data=%02h last=%0b, want v=1 ch=%0d data=%02h last=%0b",
                     rr_out_valid, rr_out_ch, rr_out_data, rr_out_last, exp.ch, exp.data, exp.last);
        end
        rr_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (rr_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL stall_ready[%0d]: got %04b, want 0000", k, rr_ready);
            end
            step();
            n_checks++;
            if (rr_out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_out[%0d]: got v=%0b ch=%0d, want v=0", k, rr_out_valid, rr_out_ch);
            end
            $display("stall cycle %0d: out_valid=%0b", k, rr_out_valid);
        end
        rr_valid = 4'b0101; rr_last = 4'b0101; rr_data = 32'h00C000A1;
        #1;
        n_checks++;
        if (rr_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL stall_resume_ready: got %04b, want 0001", rr_ready);
        end
        q_rr.push_back('{ch: 2'd0, data: 8'hA1, last: 1'b1});
        step();
        exp = q_rr.pop_front();
        n_checks++;
        if (rr_out_valid !== 1'b1 || rr_out_ch !== exp.ch || rr_out_data !== exp.data || rr_out_last !== exp.last) begin
            n_fail++;
            $display("FAIL stall_tail: got v=%0b ch=%0d data=%02h last=%0b, want v=1 ch=%0d data=%02h last=%0b",
                     rr_out_valid, rr_out_ch, rr_out_data, rr_out_last, exp.ch, exp.data, exp.last);
        end
        rr_valid = 4'b0100;
        #1;
        n_checks++;
        if (rr_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL stall_ch2_ready: got %04b, want 0100", rr_ready);
        end
        q_rr.push_back('{ch: 2'd2, data: 8'hC0, last: 1'b1});
        step();
        exp = q_rr.pop_front();
        n_checks++;
        if (rr_out_valid !== 1'b1 || rr_out_ch !== exp.ch || rr_out_data !== exp.data) begin
            n_fail++;
            $display("FAIL stall_ch2_beat: got v=%0b ch=%0d data=%02h, want v=1 ch=%0d data=%02h",
                     rr_out_valid, rr_out_ch, rr_out_data, exp.ch, exp.data);
        end
        idle_inputs();
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_fixed_priority();
        test_lock_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
